// File: rtl/mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb
// Purpose  : Two-port memory arbiter with lock-held ownership and one-beat
//            alternation. Optional burst cap: define MEM_ARB_BURST_LIMIT_EN.
// Revision : 1.0
// ============================================================================
module mem_arb #(
   parameter int BURST_MAX = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        p0_req,
   input  logic        p0_lock,
   input  logic        p0_we,
   input  logic [15:0] p0_addr,
   input  logic [31:0] p0_wdata,
   output logic        p0_gnt,
   output logic        p0_rvalid,
   output logic [31:0] p0_rdata,
   input  logic        p1_req,
   input  logic        p1_lock,
   input  logic        p1_we,
   input  logic [15:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p1_gnt,
   output logic        p1_rvalid,
   output logic [31:0] p1_rdata,
   output logic [15:0] mem_addr,
   output logic [31:0] mem_dataW,
   output logic        mem_en,
   output logic        mem_we,
   input  logic [31:0] mem_dataR
);

   typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

   state_t state_q, state_d;
   logic   last_q;
   logic   rvalid0_q, rvalid1_q;
   logic   w_gnt0, w_gnt1;
   logic   w_burst_done;

   assign w_gnt0 = (state_q == OWN0) && p0_req;
   assign w_gnt1 = (state_q == OWN1) && p1_req;
   assign p0_gnt = w_gnt0;
   assign p1_gnt = w_gnt1;

`ifdef MEM_ARB_BURST_LIMIT_EN
   localparam int CNT_W = $clog2(BURST_MAX) + 1;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The current granted beat is counted, so the cap fires on the last allowed beat.
   assign w_burst_done = (w_gnt0 || w_gnt1) && (cnt_q == CNT_W'(BURST_MAX - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (w_gnt0 || w_gnt1) begin
         cnt_d = w_burst_done ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
`else
   assign w_burst_done = 1'b0;
   // Lock holds ownership indefinitely; BURST_MAX is accepted but has no effect.
   if (BURST_MAX > 0) begin : g_no_burst_limit
   end
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (p0_req && p1_req) state_d = last_q ? OWN0 : OWN1;
            else if (p0_req)      state_d = OWN0;
            else if (p1_req)      state_d = OWN1;
         end
         OWN0: begin
            if (!p0_req)                      state_d = p1_req ? OWN1 : IDLE;
            else if (!p0_lock || w_burst_done) state_d = p1_req ? OWN1 : OWN0;
         end
         OWN1: begin
            if (!p1_req)                      state_d = p0_req ? OWN0 : IDLE;
            else if (!p1_lock || w_burst_done) state_d = p0_req ? OWN0 : OWN1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         last_q    <= 1'b1;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rvalid0_q <= w_gnt0 && !p0_we;
         rvalid1_q <= w_gnt1 && !p1_we;
         if (w_gnt0)      last_q <= 1'b0;
         else if (w_gnt1) last_q <= 1'b1;
      end
   end

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_dataW = '0;
      if (w_gnt0) begin
         mem_en    = 1'b1;
         mem_we    = p0_we;
         mem_addr  = p0_addr;
         mem_dataW = p0_wdata;
      end else if (w_gnt1) begin
         mem_en    = 1'b1;
         mem_we    = p1_we;
         mem_addr  = p1_addr;
         mem_dataW = p1_wdata;
      end
   end

   assign p0_rvalid = rvalid0_q;
   assign p1_rvalid = rvalid1_q;
   assign p0_rdata  = rvalid0_q ? mem_dataR : 32'h0;
   assign p1_rdata  = rvalid1_q ? mem_dataR : 32'h0;

endmodule
`default_nettype wire
